// File: rtl/rsa_pkg.sv
// Shared types for the RSA datapath blocks.
// Holds the modular multiplier FSM encoding and default width.
package rsa_pkg;

  localparam int RSA_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    MULT,
    DONE
  } modmult_state_t;

endpackage

// File: rtl/modmult_step.sv
// One interleaved shift-add-reduce step: (2*r + bit*x) mod n.
// Valid while r < n and x < n, so the sum stays below 3n.
module modmult_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_r,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_r_next
);

  logic [WIDTH+1:0] w_n;
  logic [WIDTH+1:0] w_add;
  logic [WIDTH+1:0] w_t;
  logic [WIDTH+1:0] w_t1;
  logic [WIDTH+1:0] w_t2;

  assign w_n   = {2'b00, i_n};
  assign w_add = i_bit ? {2'b00, i_x} : '0;
  assign w_t   = {1'b0, i_r, 1'b0} + w_add;

  // Two conditional subtractions bring t from [0, 3n) into [0, n).
  assign w_t1 = (w_t >= w_n) ? (w_t - w_n) : w_t;
  assign w_t2 = (w_t1 >= w_n) ? (w_t1 - w_n) : w_t1;

  assign o_r_next = w_t2[WIDTH-1:0];

endmodule

// File: rtl/modmult_interleaved.sv
// Bit-serial modular multiplier: result = (a * b) mod n.
// Fixed latency regardless of operand values.
module modmult_interleaved
  import rsa_pkg::*;
#(
  parameter int WIDTH    = RSA_WIDTH_DEFAULT,
  parameter bit REDUCE_A = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  modmult_state_t   r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_result;
  logic             r_error;

  logic             w_reduce;
  logic             w_bit;
  logic             w_last;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_next;

  // REDUCE walks a with x=1; MULT walks b with x=a_red.
  assign w_reduce = (r_state == REDUCE);
  assign w_bit    = w_reduce ? r_a[r_cnt] : r_b[r_cnt];
  assign w_x      = w_reduce ? WIDTH'(1) : r_a;
  assign w_last   = (r_cnt == '0);

  modmult_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_r     (r_r),
    .i_bit   (w_bit),
    .i_x     (w_x),
    .i_n     (r_n),
    .o_r_next(w_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_n      <= '0;
      r_r      <= '0;
      r_result <= '0;
      r_error  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_n     <= n;
            r_r     <= '0;
            r_cnt   <= CNT_MAX;
            r_error <= 1'b0;
            if (n == '0) begin
              r_state  <= DONE;
              r_error  <= 1'b1;
              r_result <= '0;
            end else if (REDUCE_A) begin
              r_state <= REDUCE;
            end else begin
              r_state <= MULT;
            end
          end
        end
        REDUCE: begin
          if (w_last) begin
            r_a     <= w_next;
            r_r     <= '0;
            r_cnt   <= CNT_MAX;
            r_state <= MULT;
          end else begin
            r_r   <= w_next;
            r_cnt <= r_cnt - CW'(1);
          end
        end
        MULT: begin
          r_r <= w_next;
          if (w_last) begin
            r_result <= w_next;
            r_state  <= DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy   = (r_state == REDUCE) || (r_state == MULT);
  assign done   = (r_state == DONE);
  assign error  = r_error;
  assign result = r_result;

endmodule

// File: tb/tb_modmult_interleaved.sv
// Scoreboard bench for modmult_interleaved, WIDTH=32.
// Covers both REDUCE_A settings, n==0, reset abort, held start.
module tb_modmult_interleaved;

  localparam int W = 32;
  localparam logic [W-1:0] ONES = '1;
  localparam logic [W-1:0] ONES_M1 = ONES - 1;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           at;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         st1 = 1'b0;
  logic         st0 = 1'b0;
  logic [W-1:0] a1 = '0, b1 = '0, n1 = '0;
  logic [W-1:0] a0 = '0, b0 = '0, n0 = '0;
  logic         busy1, done1, err1;
  logic         busy0, done0, err0;
  logic [W-1:0] res1, res0;

  exp_t q1[$];
  exp_t q0[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   stab_err = 0;
  logic [W-1:0] last1 = '0;

  modmult_interleaved #(.WIDTH(W), .REDUCE_A(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .start(st1),
    .a(a1), .b(b1), .n(n1),
    .busy(busy1), .done(done1), .error(err1), .result(res1)
  );

  modmult_interleaved #(.WIDTH(W), .REDUCE_A(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .start(st0),
    .a(a0), .b(b0), .n(n0),
    .busy(busy0), .done(done0), .error(err0), .result(res0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done1) begin
      if (q1.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dut1 unexpected done: edge %0d result %0h",
                 cyc + 1, res1);
      end else begin
        e = q1.pop_front();
        chk("dut1 result", res1, e.res);
        chk("dut1 error", err1, e.err);
        chk("dut1 done edge", cyc + 1, e.at);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done0) begin
      if (q0.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dut0 unexpected done: edge %0d result %0h",
                 cyc + 1, res0);
      end else begin
        e = q0.pop_front();
        chk("dut0 result", res0, e.res);
        chk("dut0 error", err0, e.err);
        chk("dut0 done edge", cyc + 1, e.at);
      end
    end
  end

  always @(negedge clk) begin
    if (reset) last1 = '0;
    else if (done1) last1 = res1;
    else if (res1 !== last1) stab_err++;
  end

  task automatic wait_done(input bit sel);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = sel ? done1 : done0;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL done timeout: dut%0d got no done expected done",
               sel);
    end
  endtask

  task automatic run(input bit sel,
                     input logic [W-1:0] a,
                     input logic [W-1:0] b,
                     input logic [W-1:0] n,
                     input logic [W-1:0] er,
                     input logic ee);
    exp_t e;
    int   lat;
    @(negedge clk);
    if (sel) begin
      a1 = a; b1 = b; n1 = n; st1 = 1'b1;
    end else begin
      a0 = a; b0 = b; n0 = n; st0 = 1'b1;
    end
    @(posedge clk);
    #1;
    st1 = 1'b0;
    st0 = 1'b0;
    lat = (n == '0) ? 1 : (sel ? 2 * W + 1 : W + 1);
    e.res = er;
    e.err = ee;
    e.at  = cyc + lat;
    if (sel) begin
      q1.push_back(e);
      chk("dut1 busy after accept", busy1, n != '0);
      chk("dut1 error after accept", err1, n == '0);
    end else begin
      q0.push_back(e);
      chk("dut0 busy after accept", busy0, n != '0);
      chk("dut0 error after accept", err0, n == '0);
    end
    wait_done(sel);
    @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout: bench still running expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e0;
    exp_t e;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy1", busy1, 0);
    chk("reset done1", done1, 0);
    chk("reset error1", err1, 0);
    chk("reset result1", res1, 0);
    chk("reset busy0", busy0, 0);
    chk("reset result0", res0, 0);
    reset = 1'b0;

    run(1, 524, 326, 31, 14, 0);
    run(0, 28, 326, 31, 14, 0);
    run(1, 9, 9, 0, 0, 1);
    run(1, 3, 5, 7, 1, 0);
    run(1, ONES, ONES, ONES, 0, 0);
    run(1, ONES_M1, ONES_M1, ONES, 1, 0);
    run(1, 0, 5, 7, 0, 0);
    run(1, 9, 0, 7, 0, 0);
    run(1, 12345, 678, 1, 0, 0);
    run(1, 10, 10, 13, 9, 0);
    run(1, ONES, 2, ONES_M1, 2, 0);
    run(0, 3, 5, 7, 1, 0);
    run(0, 4, 4, 0, 0, 1);
    run(0, ONES_M1, ONES_M1, ONES, 1, 0);

    // reset abort at edge 20 of an operation
    @(negedge clk);
    a1 = 524; b1 = 326; n1 = 31; st1 = 1'b1;
    @(posedge clk);
    #1;
    st1 = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort busy", busy1, 0);
    chk("abort done", done1, 0);
    chk("abort result", res1, 0);
    repeat (100) @(negedge clk);
    chk("abort result later", res1, 0);
    run(1, 524, 326, 31, 14, 0);

    // start held high: one op per 2*W+2 cycles
    @(negedge clk);
    a1 = 100; b1 = 200; n1 = 1009; st1 = 1'b1;
    e0 = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      e.res = 829;
      e.err = 1'b0;
      e.at  = e0 + 2 * W + 1 + k * (2 * W + 2);
      q1.push_back(e);
    end
    for (int k = 0; k < 3; k++) wait_done(1);
    st1 = 1'b0;
    repeat (150) @(negedge clk);

    chk("dut1 queue drained", q1.size(), 0);
    chk("dut0 queue drained", q0.size(), 0);
    chk("result stable", stab_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
